// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS data-memory arbiter.
// The response-pipeline tag records everything needed to finish a read when its data returns.
package mem_arb_pkg;

  localparam int unsigned PKG_DATA_W = 32;
  localparam int unsigned BYTE_LANES = PKG_DATA_W / 8;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} ls_size_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [1:0] a;
    ls_size_e   size;
    logic       uns;
  } rsp_tag_t;

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane steering for the load/store unit: store enables and replicated data,
// misalignment detection, and load-data shift with sign/zero extension.
module ls_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]            i_ls_a,
  input  logic [1:0]            i_ls_size,
  input  logic [PKG_DATA_W-1:0] i_st_wdata,
  output logic                  o_err,
  output logic [BYTE_LANES-1:0] o_st_be,
  output logic [PKG_DATA_W-1:0] o_st_wdata,
  input  logic [1:0]            i_ld_a,
  input  logic [1:0]            i_ld_size,
  input  logic                  i_ld_uns,
  input  logic [PKG_DATA_W-1:0] i_ld_data,
  output logic [PKG_DATA_W-1:0] o_ld_data
);

  ls_size_e                w_st_size;
  ls_size_e                w_ld_size;
  logic [PKG_DATA_W-1:0]   w_shift;

  assign w_st_size = ls_size_e'(i_ls_size);
  assign w_ld_size = ls_size_e'(i_ld_size);
  assign w_shift   = i_ld_data >> {i_ld_a, 3'b000};

  always_comb begin
    o_err      = 1'b0;
    o_st_be    = '0;
    o_st_wdata = i_st_wdata;
    unique case (w_st_size)
      SZ_B: begin
        o_st_be    = BYTE_LANES'(1) << i_ls_a;
        o_st_wdata = {BYTE_LANES{i_st_wdata[7:0]}};
      end
      SZ_H: begin
        o_err      = i_ls_a[0];
        o_st_be    = BYTE_LANES'(3) << i_ls_a;
        o_st_wdata = {(BYTE_LANES / 2){i_st_wdata[15:0]}};
      end
      SZ_W: begin
        o_err   = (i_ls_a != 2'b00);
        o_st_be = '1;
      end
      default: o_err = 1'b1;
    endcase
    if (o_err) o_st_be = '0;
  end

  always_comb begin
    o_ld_data = i_ld_data;
    unique case (w_ld_size)
      SZ_B:    o_ld_data = {{(PKG_DATA_W - 8){~i_ld_uns & w_shift[7]}}, w_shift[7:0]};
      SZ_H:    o_ld_data = {{(PKG_DATA_W - 16){~i_ld_uns & w_shift[15]}}, w_shift[15:0]};
      default: o_ld_data = i_ld_data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between instruction fetch and the load/store unit,
// with a starvation guard for IF and a fixed-latency read-response pipeline.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_if_req,
  input  logic [ADDR_W+1:0] in_if_addr,
  output logic              out_if_gnt,
  output logic              out_if_rvalid,
  output logic [DATA_W-1:0] out_if_rdata,
  input  logic              in_ls_req,
  input  logic              in_ls_we,
  input  logic [ADDR_W+1:0] in_ls_addr,
  input  logic [1:0]        in_ls_size,
  input  logic              in_ls_unsigned,
  input  logic [DATA_W-1:0] in_ls_wdata,
  output logic              out_ls_gnt,
  output logic              out_ls_err,
  output logic              out_ls_rvalid,
  output logic [DATA_W-1:0] out_ls_rdata,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_re_web,
  output logic [DATA_W-1:0] out_mem_write_data,
  output logic [3:0]        out_mem_byte_en,
  input  logic [DATA_W-1:0] in_mem_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  r_starve;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  rsp_tag_t          r_pipe [MEM_LAT];

  logic              w_starved;
  logic              w_err;
  logic              w_ls_ok;
  logic              w_ls_rd;
  logic [3:0]        w_st_be;
  logic [DATA_W-1:0] w_st_wdata;
  logic [DATA_W-1:0] w_ld_data;
  rsp_tag_t          w_tag;
  rsp_tag_t          w_rsp;
  logic              w_unused_if_lo;

  assign w_unused_if_lo = ^in_if_addr[1:0];

  // Grants are gated by reset so every output sits at its reset value while held.
  assign w_starved  = (r_starve == CNT_W'(STARVE_MAX));
  assign out_if_gnt = i_rst & in_if_req & (~in_ls_req | w_starved);
  assign out_ls_gnt = i_rst & in_ls_req & ~out_if_gnt;
  assign out_ls_err = out_ls_gnt & w_err;
  assign w_ls_ok    = out_ls_gnt & ~w_err;
  assign w_ls_rd    = w_ls_ok & ~in_ls_we;

  ls_lane_align u_align (
    .i_ls_a     (in_ls_addr[1:0]),
    .i_ls_size  (in_ls_size),
    .i_st_wdata (in_ls_wdata),
    .o_err      (w_err),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_a     (w_rsp.a),
    .i_ld_size  (w_rsp.size),
    .i_ld_uns   (w_rsp.uns),
    .i_ld_data  (in_mem_data),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    out_mem_addr       = r_mem_addr;
    out_mem_re_web     = 1'b1;
    out_mem_byte_en    = '0;
    out_mem_write_data = '0;
    if (out_if_gnt) begin
      out_mem_addr = in_if_addr[ADDR_W+1:2];
    end else if (w_ls_ok) begin
      out_mem_addr = in_ls_addr[ADDR_W+1:2];
      if (in_ls_we) begin
        out_mem_re_web     = 1'b0;
        out_mem_byte_en    = w_st_be;
        out_mem_write_data = w_st_wdata;
      end
    end
  end

  always_comb begin
    w_tag       = '0;
    w_tag.valid = out_if_gnt | w_ls_rd;
    w_tag.owner = out_if_gnt ? OWN_IF : OWN_LS;
    w_tag.a     = in_ls_addr[1:0];
    w_tag.size  = ls_size_e'(in_ls_size);
    w_tag.uns   = in_ls_unsigned;
  end

  assign w_rsp         = r_pipe[MEM_LAT-1];
  assign out_if_rvalid = w_rsp.valid & (w_rsp.owner == OWN_IF);
  assign out_ls_rvalid = w_rsp.valid & (w_rsp.owner == OWN_LS);
  assign out_if_rdata  = out_if_rvalid ? in_mem_data : r_if_rdata;
  assign out_ls_rdata  = out_ls_rvalid ? w_ld_data : r_ls_rdata;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_starve   <= '0;
      r_mem_addr <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
      for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
    end else begin
      if (!in_if_req || out_if_gnt) r_starve <= '0;
      else if (!w_starved)          r_starve <= r_starve + CNT_W'(1);
      r_mem_addr <= out_mem_addr;
      r_pipe[0]  <= w_tag;
      for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (out_if_rvalid) r_if_rdata <= in_mem_data;
      if (out_ls_rvalid) r_ls_rdata <= w_ld_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=1) with a synchronous backing memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we, ls_uns;
  logic [11:0] if_addr, ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_err, ls_rvalid, mem_re_web;
  logic [31:0] if_rdata, ls_rdata, mem_wdata, rd_q;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem [1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .in_if_req          (if_req),
    .in_if_addr         (if_addr),
    .out_if_gnt         (if_gnt),
    .out_if_rvalid      (if_rvalid),
    .out_if_rdata       (if_rdata),
    .in_ls_req          (ls_req),
    .in_ls_we           (ls_we),
    .in_ls_addr         (ls_addr),
    .in_ls_size         (ls_size),
    .in_ls_unsigned     (ls_uns),
    .in_ls_wdata        (ls_wdata),
    .out_ls_gnt         (ls_gnt),
    .out_ls_err         (ls_err),
    .out_ls_rvalid      (ls_rvalid),
    .out_ls_rdata       (ls_rdata),
    .out_mem_addr       (mem_addr),
    .out_mem_re_web     (mem_re_web),
    .out_mem_write_data (mem_wdata),
    .out_mem_byte_en    (mem_be),
    .in_mem_data        (rd_q)
  );

  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[mem_addr];
    if (!mem_re_web) begin
      for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[mem_addr] <= w;
    end
    rd_q <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [11:0] ia, input logic lr, input logic we,
                       input logic [11:0] la, input logic [1:0] sz, input logic un,
                       input logic [31:0] wd);
    @(negedge clk);
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = we;
    ls_addr = la; ls_size = sz; ls_uns = un; ls_wdata = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " if_gnt"}, if_gnt, 0);
    chk({tag, " ls_gnt"}, ls_gnt, 0);
    chk({tag, " ls_err"}, ls_err, 0);
    chk({tag, " if_rvalid"}, if_rvalid, 0);
    chk({tag, " ls_rvalid"}, ls_rvalid, 0);
    chk({tag, " if_rdata"}, if_rdata, 0);
    chk({tag, " ls_rdata"}, ls_rdata, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " re_web"}, mem_re_web, 1);
    chk({tag, " byte_en"}, mem_be, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_size = 0; ls_uns = 0; ls_wdata = 0;
    repeat (2) @(negedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst_n = 1'b1;

    // 1: reset lands while an IF read is in flight
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk("t1 if_gnt", if_gnt, 1);
    chk("t1 mem_addr", mem_addr, 10'h004);
    @(posedge clk);
    #1 rst_n = 1'b0; if_req = 1'b0;
    #1 chk_reset("t1 rst");
    @(negedge clk) rst_n = 1'b1;
    idle(); chk("t1 no rvalid a", if_rvalid, 0);
    idle(); chk("t1 no rvalid b", if_rvalid, 0);

    // 2: store byte then unsigned load byte
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h103, 2'b00, 1'b0, 32'h0000_00AB);
    chk("t2 st gnt", ls_gnt, 1);
    chk("t2 st err", ls_err, 0);
    chk("t2 st re_web", mem_re_web, 0);
    chk("t2 st byte_en", mem_be, 4'b1000);
    chk("t2 st wdata", mem_wdata, 32'hABAB_ABAB);
    chk("t2 st addr", mem_addr, 10'h040);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h103, 2'b00, 1'b1, 32'h0);
    chk("t2 ld re_web", mem_re_web, 1);
    chk("t2 ld byte_en", mem_be, 0);
    idle();
    chk("t2 ld rvalid", ls_rvalid, 1);
    chk("t2 ld rdata", ls_rdata, 32'h0000_00AB);
    idle();
    chk("t2 rvalid drop", ls_rvalid, 0);
    chk("t2 rdata hold", ls_rdata, 32'h0000_00AB);

    // 3: signed half/byte extraction from a stored word
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h200, 2'b10, 1'b0, 32'h80F0_7F01);
    chk("t3 st byte_en", mem_be, 4'b1111);
    chk("t3 st wdata", mem_wdata, 32'h80F0_7F01);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h202, 2'b01, 1'b0, 32'h0);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h201, 2'b00, 1'b0, 32'h0);
    chk("t3 half rvalid", ls_rvalid, 1);
    chk("t3 half rdata", ls_rdata, 32'hFFFF_80F0);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h203, 2'b00, 1'b0, 32'h0);
    chk("t3 byte1 rdata", ls_rdata, 32'h0000_007F);
    idle();
    chk("t3 byte3 rdata", ls_rdata, 32'hFFFF_FF80);

    // 4: contention, IF forced through after four denials
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 12'h000, 1'b1, 1'b0, 12'h004, 2'b10, 1'b0, 32'h0);
      chk($sformatf("t4 if_gnt c%0d", k), if_gnt, (k % 5 == 4));
      chk($sformatf("t4 ls_gnt c%0d", k), ls_gnt, (k % 5 != 4));
      if (k > 0) chk($sformatf("t4 if_rvalid c%0d", k), if_rvalid, ((k - 1) % 5 == 4));
    end
    idle();
    chk("t4 last if_rvalid", if_rvalid, 1);
    chk("t4 last if_rdata", if_rdata, 32'h1111_1111);
    idle();

    // 5: misaligned / illegal requests
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h006, 2'b10, 1'b0, 32'h0);
    chk("t5 ldw gnt", ls_gnt, 1);
    chk("t5 ldw err", ls_err, 1);
    chk("t5 ldw byte_en", mem_be, 0);
    chk("t5 ldw addr hold", mem_addr, 10'h000);
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h101, 2'b01, 1'b0, 32'hFFFF_FFFF);
    chk("t5 sth err", ls_err, 1);
    chk("t5 sth re_web", mem_re_web, 1);
    chk("t5 sth byte_en", mem_be, 0);
    chk("t5 sth addr hold", mem_addr, 10'h000);
    chk("t5 ldw no rvalid", ls_rvalid, 0);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h104, 2'b11, 1'b0, 32'h0);
    chk("t5 sz11 err", ls_err, 1);
    chk("t5 sz11 gnt", ls_gnt, 1);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h100, 2'b10, 1'b0, 32'h0);
    chk("t5 sz11 no rvalid", ls_rvalid, 0);
    chk("t5 ldw100 err", ls_err, 0);
    idle();
    chk("t5 word untouched", ls_rdata, 32'hAB00_0000);

    // 6: back-to-back mixed reads return in grant order
    drive(1'b1, 12'h000, 1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk("t6 if0 gnt", if_gnt, 1);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h004, 2'b10, 1'b0, 32'h0);
    chk("t6 if0 rvalid", if_rvalid, 1);
    chk("t6 if0 rdata", if_rdata, 32'h1111_1111);
    drive(1'b1, 12'h008, 1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk("t6 ls rvalid", ls_rvalid, 1);
    chk("t6 ls rdata", ls_rdata, 32'h2222_2222);
    chk("t6 ls slot if_rvalid", if_rvalid, 0);
    idle();
    chk("t6 if8 rvalid", if_rvalid, 1);
    chk("t6 if8 rdata", if_rdata, 32'h3333_3333);
    chk("t6 if8 ls_rvalid", ls_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
